// File: rtl/sram22_port_arbiter.sv
// Two-port front end for a single-port sram22 macro: combinational grant, 1-cycle read response.
// Build option SRAM22_ARB_RR_EN selects round-robin contention handling (default: port 0 priority).
module sram22_port_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   p0_valid,
  output logic                   p0_ready,
  input  logic                   p0_we,
  input  logic [WMASK_WIDTH-1:0] p0_wmask,
  input  logic [ADDR_WIDTH-1:0]  p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic                   p0_rvalid,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  input  logic                   p1_valid,
  output logic                   p1_ready,
  input  logic                   p1_we,
  input  logic [WMASK_WIDTH-1:0] p1_wmask,
  input  logic [ADDR_WIDTH-1:0]  p1_addr,
  input  logic [DATA_WIDTH-1:0]  p1_wdata,
  output logic                   p1_rvalid,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  logic gnt0, gnt1;
  logic last_grant;
  logic rd_pend, rd_port;

  // rstb gates the grant directly so nothing reaches the macro while reset is held
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstb) begin
      if (p0_valid && p1_valid) begin
`ifdef SRAM22_ARB_RR_EN
        gnt0 = last_grant;
        gnt1 = ~last_grant;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = p0_valid;
        gnt1 = p1_valid;
      end
    end
  end

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;
  assign sram_ce  = gnt0 | gnt1;

  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (gnt1) begin
      sram_we    = p1_we;
      sram_wmask = p1_wmask;
      sram_addr  = p1_addr;
      sram_din   = p1_wdata;
    end else if (gnt0) begin
      sram_we    = p0_we;
      sram_wmask = p0_wmask;
      sram_addr  = p0_addr;
      sram_din   = p0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_port    <= 1'b0;
    end else begin
      rd_pend <= (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
      rd_port <= gnt1;
      if (gnt0)
        last_grant <= 1'b0;
      else if (gnt1)
        last_grant <= 1'b1;
    end
  end

  assign p0_rvalid = rd_pend & ~rd_port;
  assign p1_rvalid = rd_pend & rd_port;
  assign p0_rdata  = sram_dout;
  assign p1_rdata  = sram_dout;

endmodule

// File: tb/tb_sram22_port_arbiter.sv
// Bench for sram22_port_arbiter: behavioural macro model, directed stimulus, response scoreboard.
module tb_sram22_port_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        p0_valid, p0_ready, p0_we, p0_rvalid;
  logic [3:0]  p0_wmask;
  logic [7:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rvalid;
  logic [3:0]  p1_wmask;
  logic [7:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic        sram_ce, sram_we;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  sram22_port_arbiter dut (
    .clk(clk), .rstb(rstb),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_wmask(p0_wmask),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_wmask(p1_wmask),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // macro model; every word preloaded with 0xC0DE0000 | address
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int l = 0; l < 4; l++)
          if (sram_wmask[l]) mem[sram_addr][8*l +: 8] <= sram_din[8*l +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int compared   = 0;
  int mismatched = 0;
  bit push_en    = 1'b1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstb && (p0_rvalid || p1_rvalid)) begin
      exp_t e;
      chk("rvalid_onehot", {31'd0, p0_rvalid & p1_rvalid}, 32'd0);
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rvalid_port", {31'd0, p1_rvalid}, {31'd0, e.port});
        chk("rdata", e.port ? p1_rdata : p0_rdata, e.data);
        chk("rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  // one request cycle; e0/e1 are the hand-derived grants, x0/x1 the expected read data
  task automatic step(
    input logic v0, input logic we0, input logic [3:0] m0, input logic [7:0] a0,
    input logic [31:0] d0, input logic e0, input logic [31:0] x0,
    input logic v1, input logic we1, input logic [3:0] m1, input logic [7:0] a1,
    input logic [31:0] d1, input logic e1, input logic [31:0] x1);
    p0_valid = v0; p0_we = we0; p0_wmask = m0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = we1; p1_wmask = m1; p1_addr = a1; p1_wdata = d1;
    @(negedge clk);
    chk("p0_ready", {31'd0, p0_ready}, {31'd0, e0});
    chk("p1_ready", {31'd0, p1_ready}, {31'd0, e1});
    chk("sram_ce", {31'd0, sram_ce}, {31'd0, e0 | e1});
    if (e0 | e1) begin
      chk("sram_addr", {24'd0, sram_addr}, {24'd0, e1 ? a1 : a0});
      chk("sram_we", {31'd0, sram_we}, {31'd0, e1 ? we1 : we0});
      if (e1 ? we1 : we0) begin
        chk("sram_wmask", {28'd0, sram_wmask}, {28'd0, e1 ? m1 : m0});
        chk("sram_din", sram_din, e1 ? d1 : d0);
      end
    end else begin
      chk("idle_we", {31'd0, sram_we}, 32'd0);
      chk("idle_wmask", {28'd0, sram_wmask}, 32'd0);
    end
    if (push_en && e0 && !we0) sbq.push_back('{1'b0, x0, cyc + 1});
    if (push_en && e1 && !we1) sbq.push_back('{1'b1, x1, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0);
  endtask

  initial begin
    int i0, i1;
    logic g0;
    rstb = 1'b0;
    // 1: reset blocks grants even with both valid
    step(1, 0, 4'h0, 8'h10, 32'h0, 0, 32'h0, 1, 0, 4'h0, 8'h11, 32'h0, 0, 32'h0);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    step(1, 0, 4'h0, 8'h10, 32'h0, 0, 32'h0, 1, 0, 4'h0, 8'h11, 32'h0, 0, 32'h0);
    rstb = 1'b1;
    step(1, 0, 4'h0, 8'h10, 32'h0, 1, 32'hC0DE0010, 0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0);
    idle();
    // 2: full write then read from the other port
    step(1, 1, 4'hF, 8'h05, 32'hDEADBEEF, 1, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0);
    step(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 1, 0, 4'h0, 8'h05, 32'h0, 1, 32'hDEADBEEF);
    idle();
    // 3: byte-lane write, then read-back; zero-mask write leaves the word alone
    step(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 1, 1, 4'b0101, 8'h05, 32'h11223344, 1, 32'h0);
    step(1, 0, 4'h0, 8'h05, 32'h0, 1, 32'hDE22BE44, 0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0);
    step(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 1, 1, 4'h0, 8'h05, 32'hFFFFFFFF, 1, 32'h0);
    step(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 1, 0, 4'h0, 8'h05, 32'h0, 1, 32'hDE22BE44);
    idle();
    // 4: four cycles of contention; each requester holds its request until accepted
    i0 = 0; i1 = 0;
    for (int c = 0; c < 4; c++) begin
`ifdef SRAM22_ARB_RR_EN
      g0 = (c % 2 == 0);
`else
      g0 = 1'b1;
`endif
      step(1, 0, 4'h0, 8'(i0), 32'h0, g0, 32'hC0DE0000 | i0,
           1, 0, 4'h0, 8'(8'h80 + i1), 32'h0, !g0, 32'hC0DE0080 + i1);
      if (g0) i0++; else i1++;
    end
    idle();
    idle();
    // 5: reset while a read is pending drops its response
    push_en = 1'b0;
    step(1, 0, 4'h0, 8'h30, 32'h0, 1, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0);
    rstb = 1'b0;
    #1;
    chk("rst_drop_rvalid", {31'd0, p0_rvalid}, 32'd0);
    step(1, 0, 4'h0, 8'h30, 32'h0, 0, 32'h0, 1, 0, 4'h0, 8'h31, 32'h0, 0, 32'h0);
    rstb = 1'b1;
    push_en = 1'b1;
    idle();
    step(1, 0, 4'h0, 8'h40, 32'h0, 1, 32'hC0DE0040, 1, 0, 4'h0, 8'h41, 32'h0, 0, 32'h0);
    idle();
    // 6: back-to-back reads from one port
    for (int c = 0; c < 8; c++) begin
      logic [7:0] a;
      a = (c % 2 == 0) ? 8'h20 : 8'h21;
      step(1, 0, 4'h0, a, 32'h0, 1, 32'hC0DE0000 | a, 0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0);
    end
    idle();
    idle();
    idle();
    chk("responses_outstanding", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
